// File: rtl/locked_core_query_ctrl_if.sv
// locked_core_query_ctrl_if: key-store, query, response and core-side signals of the
// locked-core query controller; slave is the controller, master is its environment.
interface locked_core_query_ctrl_if #(
    parameter int N_IN  = 20,
    parameter int N_OUT = 24,
    parameter int KEY_W = 16
);
    logic             key_load_start;
    logic             key_sin;
    logic             key_sin_valid;
    logic             key_ready;
    logic             q_valid;
    logic             q_ready;
    logic [N_IN-1:0]  q_data;
    logic             r_valid;
    logic             r_ready;
    logic [N_OUT-1:0] r_data;
    logic [N_IN-1:0]  core_in;
    logic [KEY_W-1:0] core_key;
    logic [N_OUT-1:0] core_out;
    logic             busy;

    modport slave (
        input  key_load_start, key_sin, key_sin_valid, q_valid, q_data, r_ready, core_out,
        output key_ready, q_ready, r_valid, r_data, core_in, core_key, busy
    );
    modport master (
        output key_load_start, key_sin, key_sin_valid, q_valid, q_data, r_ready, core_out,
        input  key_ready, q_ready, r_valid, r_data, core_in, core_key, busy
    );
endinterface

// File: rtl/locked_core_query_ctrl.sv
// locked_core_query_ctrl: serially loads and atomically commits the core key, then
// applies one query vector at a time, waits the settle window and returns the capture.
module locked_core_query_ctrl #(
    parameter int N_IN   = 20,
    parameter int N_OUT  = 24,
    parameter int KEY_W  = 16,
    parameter int SETTLE = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    locked_core_query_ctrl_if.slave bus_io
);
    localparam int CW = $clog2(KEY_W + 1);

    typedef enum logic [2:0] {NOKEY, LOAD, READY, APPLY, SETTLE_W, RESP} state_t;

    state_t           state_q, state_d;
    logic [KEY_W-1:0] shadow_q, shadow_d, core_key_q;
    logic [CW-1:0]    cnt_q;
    logic [3:0]       settle_q;
    logic [N_IN-1:0]  core_in_q;
    logic [N_OUT-1:0] r_data_q;
    logic             key_ready_q, q_ready_q, r_valid_q, busy_q;
    logic             start, last_bit;

    assign start    = bus_io.key_load_start;
    // Shadow is cleared at every load start, so OR-ing in the new bit is an insert.
    assign shadow_d = shadow_q | (KEY_W'(bus_io.key_sin) << cnt_q);
    assign last_bit = bus_io.key_sin_valid && cnt_q == CW'(KEY_W - 1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            NOKEY:    state_d = start ? LOAD : NOKEY;
            LOAD:     state_d = (!start && last_bit) ? READY : LOAD;
            READY:    state_d = start ? LOAD : bus_io.q_valid ? APPLY : READY;
            APPLY:    state_d = SETTLE_W;
            SETTLE_W: state_d = (settle_q == 4'd0) ? RESP : SETTLE_W;
            RESP:     state_d = bus_io.r_ready ? READY : RESP;
            default:  state_d = NOKEY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= NOKEY;
            shadow_q    <= '0;
            cnt_q       <= '0;
            core_key_q  <= '0;
            settle_q    <= '0;
            core_in_q   <= '0;
            r_data_q    <= '0;
            key_ready_q <= 1'b0;
            q_ready_q   <= 1'b0;
            r_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_ready_q <= state_d == READY;
            busy_q    <= !(state_d inside {NOKEY, READY});
            if (start && state_q inside {NOKEY, LOAD, READY}) begin
                shadow_q <= '0;
                cnt_q    <= '0;
            end else if (state_q == LOAD && bus_io.key_sin_valid) begin
                shadow_q <= shadow_d;
                cnt_q    <= cnt_q + CW'(1);
            end
            if (state_q == LOAD && state_d == READY) begin
                core_key_q  <= shadow_d;
                key_ready_q <= 1'b1;
            end
            if (state_q == READY && start)
                key_ready_q <= 1'b0;
            if (state_q == READY && state_d == APPLY)
                core_in_q <= bus_io.q_data;
            if (state_q == APPLY)
                settle_q <= 4'(SETTLE - 1);
            if (state_q == SETTLE_W)
                settle_q <= settle_q - 4'd1;
            if (state_q == SETTLE_W && state_d == RESP) begin
                r_data_q  <= bus_io.core_out;
                r_valid_q <= 1'b1;
            end
            if (state_q == RESP && bus_io.r_ready)
                r_valid_q <= 1'b0;
        end
    end

    assign bus_io.key_ready = key_ready_q;
    assign bus_io.q_ready   = q_ready_q;
    assign bus_io.r_valid   = r_valid_q;
    assign bus_io.r_data    = r_data_q;
    assign bus_io.core_in   = core_in_q;
    assign bus_io.core_key  = core_key_q;
    assign bus_io.busy      = busy_q;
endmodule

// File: tb/tb_locked_core_query_ctrl.sv
// tb_locked_core_query_ctrl: directed stimulus with a transaction-level reference model
// checked every cycle, plus literal expectations at the key points of each scenario.
module tb_locked_core_query_ctrl;
    localparam int SETTLE = 2;
    localparam int M_NOKEY = 0, M_LOAD = 1, M_READY = 2, M_FLIGHT = 3, M_RESP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_pass = 0, n_tot = 0, cyc = 0;
    bit   chk_on = 1'b0;

    locked_core_query_ctrl_if bus ();
    locked_core_query_ctrl #(.SETTLE(SETTLE)) dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Stand-in for the locked core: one fixed vector maps to a known constant.
    function automatic logic [23:0] core_fn(logic [19:0] x, logic [15:0] k);
        return (x == 20'h5A5A5) ? 24'hC0FFEE : ({4'h0, x} ^ {8'h0, k});
    endfunction
    assign bus.core_out = core_fn(bus.core_in, bus.core_key);

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    int          m_mode = M_NOKEY, m_nbits = 0, m_wait = 0;
    logic [15:0] m_shadow = '0, m_key = '0;
    logic [19:0] m_in = '0;
    logic [23:0] m_rdata = '0;
    logic        m_kr = 1'b0, m_rv = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_NOKEY; m_nbits = 0; m_wait = 0; m_shadow = '0; m_key = '0;
            m_in = '0; m_rdata = '0; m_kr = 1'b0; m_rv = 1'b0;
        end else begin
            case (m_mode)
                M_NOKEY, M_LOAD:
                    if (bus.key_load_start) begin
                        m_mode = M_LOAD; m_nbits = 0; m_shadow = '0;
                    end else if (m_mode == M_LOAD && bus.key_sin_valid) begin
                        m_shadow[m_nbits] = bus.key_sin;
                        m_nbits++;
                        if (m_nbits == 16) begin
                            m_key = m_shadow; m_kr = 1'b1; m_mode = M_READY;
                        end
                    end
                M_READY:
                    if (bus.key_load_start) begin
                        m_mode = M_LOAD; m_kr = 1'b0; m_nbits = 0; m_shadow = '0;
                    end else if (bus.q_valid) begin
                        m_in = bus.q_data; m_wait = SETTLE + 1; m_mode = M_FLIGHT;
                    end
                M_FLIGHT: begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_rdata = core_fn(m_in, m_key); m_rv = 1'b1; m_mode = M_RESP;
                    end
                end
                M_RESP:
                    if (bus.r_ready) begin
                        m_rv = 1'b0; m_mode = M_READY;
                    end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("key_ready", bus.key_ready, m_kr);
            chk("core_key", bus.core_key, m_key);
            chk("q_ready", bus.q_ready, m_mode == M_READY);
            chk("busy", bus.busy, m_mode inside {M_LOAD, M_FLIGHT, M_RESP});
            chk("core_in", bus.core_in, m_in);
            chk("r_valid", bus.r_valid, m_rv);
            chk("r_data", bus.r_data, m_rdata);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(logic b, bit gap);
        if (gap) begin
            bus.key_sin_valid = 1'b0;
            tick;
        end
        bus.key_sin_valid = 1'b1;
        bus.key_sin = b;
        tick;
        bus.key_sin_valid = 1'b0;
    endtask

    task automatic start_load(logic [15:0] v, bit gap, int n);
        bus.key_load_start = 1'b1;
        tick;
        bus.key_load_start = 1'b0;
        for (int i = 0; i < n; i++) send_bit(v[i], gap);
    endtask

    task automatic query(logic [19:0] d, output int acc);
        int n = 0;
        while (!bus.q_ready && n < 50) begin
            tick;
            n++;
        end
        chk("q_ready_wait", bus.q_ready, 1);
        bus.q_valid = 1'b1;
        bus.q_data = d;
        tick;
        bus.q_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_resp;
        int n = 0;
        while (!bus.r_valid && n < 20) begin
            tick;
            n++;
        end
        chk("r_valid_wait", bus.r_valid, 1);
    endtask

    task automatic handshake;
        bus.r_ready = 1'b1;
        tick;
        bus.r_ready = 1'b0;
    endtask

    initial begin
        int t;
        int acc[3];
        logic [19:0] vecs[3] = '{20'h11111, 20'h2468A, 20'h0F0F0};
        logic [15:0] k1234 = 16'h1234;
        bus.key_load_start = 0; bus.key_sin = 0; bus.key_sin_valid = 0;
        bus.q_valid = 0; bus.q_data = '0; bus.r_ready = 0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_on = 1'b1;
        chk("rst_key_ready", bus.key_ready, 0);
        chk("rst_q_ready", bus.q_ready, 0);
        chk("rst_core_key", bus.core_key, 0);
        chk("rst_busy", bus.busy, 0);
        tick;

        start_load(16'hA5C3, 0, 15);
        chk("a5c3_before_commit", bus.core_key, 0);
        chk("a5c3_kr_before", bus.key_ready, 0);
        send_bit(1'b1, 0);
        chk("a5c3_commit", bus.core_key, 16'hA5C3);
        chk("a5c3_kr", bus.key_ready, 1);
        chk("a5c3_q_ready", bus.q_ready, 1);

        start_load(16'h0001, 1, 15);
        chk("gap_old_key_kept", bus.core_key, 16'hA5C3);
        chk("gap_kr_low", bus.key_ready, 0);
        send_bit(1'b0, 1);
        chk("gap_commit", bus.core_key, 16'h0001);
        chk("gap_kr", bus.key_ready, 1);

        query(20'h5A5A5, t);
        tick;
        chk("q1_rv_t1", bus.r_valid, 0);
        tick;
        chk("q1_rv_t2", bus.r_valid, 0);
        tick;
        chk("q1_rv_t3", bus.r_valid, 1);
        chk("q1_latency", cyc - t, 3);
        chk("q1_rdata", bus.r_data, 24'hC0FFEE);
        repeat (5) begin
            tick;
            chk("q1_hold_rdata", bus.r_data, 24'hC0FFEE);
            chk("q1_hold_rv", bus.r_valid, 1);
        end
        handshake;
        chk("q1_rv_drop", bus.r_valid, 0);
        chk("q1_q_ready_back", bus.q_ready, 1);

        bus.key_load_start = 1'b1;
        bus.q_valid = 1'b1;
        bus.q_data = 20'hFFFFF;
        tick;
        bus.key_load_start = 1'b0;
        bus.q_valid = 1'b0;
        chk("prio_kr", bus.key_ready, 0);
        chk("prio_q_ready", bus.q_ready, 0);
        chk("prio_busy", bus.busy, 1);
        chk("prio_core_in", bus.core_in, 20'h5A5A5);
        for (int i = 0; i < 16; i++) send_bit(k1234[i], 0);
        chk("prio_commit", bus.core_key, 16'h1234);
        query(20'h00123, t);
        wait_resp;
        chk("prio_rdata", bus.r_data, 24'h001317);
        handshake;

        start_load(16'h007F, 0, 7);
        start_load(16'hFFFF, 0, 15);
        chk("restart_kr_low", bus.key_ready, 0);
        chk("restart_key_kept", bus.core_key, 16'h1234);
        send_bit(1'b1, 0);
        chk("restart_commit", bus.core_key, 16'hFFFF);
        query(20'h0000F, t);
        wait_resp;
        chk("restart_rdata", bus.r_data, 24'h00FFF0);
        handshake;

        bus.r_ready = 1'b1;
        for (int i = 0; i < 3; i++) query(vecs[i], acc[i]);
        chk("tput_0_1", acc[1] - acc[0], 5);
        chk("tput_1_2", acc[2] - acc[1], 5);
        wait_resp;
        tick;
        bus.r_ready = 1'b0;

        query(20'hABCDE, t);
        tick;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_r_valid", bus.r_valid, 0);
        chk("arst_key_ready", bus.key_ready, 0);
        chk("arst_q_ready", bus.q_ready, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_core_in", bus.core_in, 0);
        chk("arst_core_key", bus.core_key, 0);
        chk("arst_r_data", bus.r_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.q_valid = 1'b1;
        bus.q_data = 20'h00001;
        repeat (4) begin
            tick;
            chk("nokey_q_ready", bus.q_ready, 0);
            chk("nokey_core_in", bus.core_in, 0);
        end
        bus.q_valid = 1'b0;
        start_load(16'hBEEF, 0, 16);
        chk("reload_commit", bus.core_key, 16'hBEEF);
        query(20'h00001, t);
        wait_resp;
        chk("reload_rdata", bus.r_data, 24'h00BEEE);
        handshake;
        repeat (2) tick;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
